broadsync_frame_sched: RTL
==========================

# broadsync_frame_sched

Frame scheduler for the BroadSync transmit path. It issues `frame_en` to the BroadSync master at a fixed bit-clock period and tracks the master's `frame_done` handshake with a timeout. It also maintains frame and timeout statistics and drives the lock bit carried in each frame. It sits between the CPU/register layer and the master, in the `ptp_clk` domain, and consumes the GTM bit-clock tick (`gtm_clk_en`).

## Interface
Parameters:
- `FRAME_PERIOD`, 128: bit-clock ticks from one frame handoff to the next; legal range 116..65535.
- `DONE_TIMEOUT`, 120: ticks after handoff before a missing `frame_done` counts as a timeout; must be < `FRAME_PERIOD`.
- `ERR_THRESH`, 3: consecutive timeouts that trigger the lock guard; range 1..15.

Ports:
- `ptp_clk`  in  1  sole clock.
- `ptp_reset`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  level; run periodic framing.
- `gtm_clk_en`  in  1  one-`ptp_clk` bit-clock tick strobe.
- `lock_src`  in  1  local servo lock status.
- `frame_done`  in  1  one-cycle pulse from the master.
- `frame_en`  out  1  frame request to the master.
- `lock_value`  out  1  lock bit presented to the master.
- `busy`  out  1  high in every state except IDLE.
- `timeout_irq`  out  1  one-cycle pulse on timeout.
- `tx_count`  out  16  completed frames; wraps 0xFFFF→0.
- `timeout_count`  out  8  timeouts; saturates at 0xFF.

## Operation
- States: IDLE, ARM, WAIT_DONE, GAP.
- IDLE: when `enable`=1 → ARM. Period and timeout counters are cleared.
- ARM: `frame_en`=1. The handoff cycle is the first cycle in ARM with `gtm_clk_en`=1. On that cycle the state goes to WAIT_DONE, and the period and timeout counters load 0.
- WAIT_DONE: each tick increments both counters.
  - `frame_done` → `tx_count`+1, clear the consecutive-timeout count, go to GAP.
  - Timeout counter reaching `DONE_TIMEOUT` on a tick → `timeout_count`+1 (saturating), `timeout_irq` pulse, consecutive-timeout count +1 (saturating at 15), go to GAP.
- GAP: the period counter keeps incrementing on ticks. When it reaches `FRAME_PERIOD`-1 on a tick → ARM if `enable`, else IDLE.
- `frame_done` and the timeout in the same cycle: done wins, no timeout is recorded.
- `frame_done` outside WAIT_DONE is ignored.
- `enable` deassertion mid-frame: the current frame completes through WAIT_DONE and GAP, then the block goes to IDLE. Deassertion in ARM before handoff → IDLE immediately, `frame_en` drops.
- `lock_value` is the registered `lock_src`, subject to the guard feature below.

## Timing
- Reset values:
  - `frame_en`, `busy`, `timeout_irq`, `lock_value` = 0.
  - `tx_count` = 0, `timeout_count` = 0.
  - State = IDLE, all counters 0.
- Reset takes effect asynchronously at any point mid-frame; a frame in flight is abandoned with no count update.
- `frame_en` is registered:
  - It rises the cycle after ARM entry.
  - It stays high through the handoff cycle inclusive (the master samples it on its `gtm_clk_en` cycle).
  - It is low the following cycle.
- The handoff-to-handoff interval is exactly `FRAME_PERIOD` ticks when `gtm_clk_en` is regular.
- Counter updates and `timeout_irq` appear one cycle after the qualifying `frame_done` or tick.
- `lock_value` has a 1-cycle latency from `lock_src`. It must be stable while `frame_en` is high.

## Configuration
- Macro: `BROADSYNC_SCHED_LOCK_GUARD_EN`.
- Defined:
  - `lock_value` is forced to 0 while the consecutive-timeout count is ≥ `ERR_THRESH`.
  - It returns to `lock_src` in the cycle after the first successful `frame_done`.
- Undefined: the consecutive-timeout counter is not built, and `lock_value` is the registered `lock_src` unconditionally.

## Structure
- Package `broadsync_sched_pkg`:
  - State enum: IDLE=0, ARM=1, WAIT_DONE=2, GAP=3.
  - `TX_CNT_W`=16, `TO_CNT_W`=8, `CONSEC_W`=4.
- Sub-module `broadsync_tick_timer`: a tick-qualified counter with synchronous clear, instantiated twice (period and timeout).

## Test plan
- `enable`=1, tick every 4 cycles, `frame_done` 115 ticks after each handoff → `frame_en` handoffs exactly 128 ticks apart; `tx_count`=3 after three frames; `timeout_count`=0.
- `frame_done` withheld → `timeout_irq` pulses once at tick 120 after handoff; `timeout_count`=1; the next handoff is still at tick 128.
- Guard build, 3 consecutive timeouts with `lock_src`=1 → `lock_value`=0 from the third timeout; the next good `frame_done` restores `lock_value`=1.
- `frame_done` on the same cycle as tick 120 → `tx_count`+1, no `timeout_irq`, `timeout_count` unchanged.
- `enable` dropped at tick 50 of WAIT_DONE → the frame completes, `tx_count`+1, IDLE after tick 127, `busy`=0, no further `frame_en`.
- `ptp_reset` asserted mid-WAIT_DONE between clock edges → all outputs 0 immediately; counts 0; framing restarts at ARM after release.

Source files
------------

// File: rtl/broadsync_sched_pkg.sv
// broadsync_sched_pkg
//   Shared types and widths for the BroadSync frame scheduler.
//   state_t    : scheduler FSM encoding (IDLE=0, ARM=1, WAIT_DONE=2, GAP=3)
//   TX_CNT_W   : width of the completed-frame counter
//   TO_CNT_W   : width of the saturating timeout counter
//   CONSEC_W   : width of the consecutive-timeout counter (lock guard)
//   TICK_CNT_W : width of the period/timeout tick counters
package broadsync_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARM       = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  localparam int TX_CNT_W   = 16;
  localparam int TO_CNT_W   = 8;
  localparam int CONSEC_W   = 4;
  localparam int TICK_CNT_W = 16;

endpackage

// File: rtl/broadsync_tick_timer.sv
// broadsync_tick_timer
//   Counter that advances by one on each bit-clock tick and can be
//   cleared synchronously. Clear has priority over tick.
// Ports:
//   clk   in  clock
//   rst   in  asynchronous active-high reset
//   clear in  synchronous clear to zero
//   tick  in  increment qualifier (one-cycle strobe)
//   count out current count
module broadsync_tick_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         tick,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/broadsync_frame_sched.sv
// broadsync_frame_sched
//   Issues frame_en to the BroadSync master once every FRAME_PERIOD
//   bit-clock ticks, watches for frame_done with a DONE_TIMEOUT-tick
//   timeout, and keeps frame/timeout statistics plus the lock bit.
//   Optional feature macro: BROADSYNC_SCHED_LOCK_GUARD_EN -- when defined,
//   lock_value is forced low after ERR_THRESH consecutive timeouts and is
//   released by the next successful frame_done.
// Handshake: frame_en is held high for the whole ARM state; the master
//   takes the request on the first cycle where frame_en and gtm_clk_en are
//   both high (the handoff), after which frame_en drops. frame_done is a
//   one-cycle pulse honoured only while waiting for it.
// Ports:
//   ptp_clk       in   clock
//   ptp_reset     in   asynchronous active-high reset
//   enable        in   run periodic framing
//   gtm_clk_en    in   bit-clock tick strobe
//   lock_src      in   local servo lock status
//   frame_done    in   completion pulse from the master
//   frame_en      out  frame request
//   lock_value    out  lock bit presented to the master
//   busy          out  high in every state except IDLE
//   timeout_irq   out  one-cycle timeout pulse
//   tx_count      out  completed frames (wrapping)
//   timeout_count out  timeouts (saturating)
module broadsync_frame_sched
  import broadsync_sched_pkg::*;
#(
  parameter int FRAME_PERIOD = 128,
  parameter int DONE_TIMEOUT = 120,
  parameter int ERR_THRESH   = 3
) (
  input  logic                ptp_clk,
  input  logic                ptp_reset,
  input  logic                enable,
  input  logic                gtm_clk_en,
  input  logic                lock_src,
  input  logic                frame_done,
  output logic                frame_en,
  output logic                lock_value,
  output logic                busy,
  output logic                timeout_irq,
  output logic [TX_CNT_W-1:0] tx_count,
  output logic [TO_CNT_W-1:0] timeout_count
);

  if (FRAME_PERIOD < 116 || FRAME_PERIOD > 65535 || DONE_TIMEOUT < 1 ||
      DONE_TIMEOUT >= FRAME_PERIOD || ERR_THRESH < 1 || ERR_THRESH > 15)
  begin : g_param_check
    $error("broadsync_frame_sched: illegal parameter set");
  end

  // Handoff is tick 0, so tick N after handoff is the tick on which the
  // counter moves from N-1 to N.
  localparam logic [TICK_CNT_W-1:0] TO_LAST  = TICK_CNT_W'(DONE_TIMEOUT - 1);
  localparam logic [TICK_CNT_W-1:0] PER_LAST = TICK_CNT_W'(FRAME_PERIOD - 2);

  state_t                  state;
  logic [TICK_CNT_W-1:0]   per_cnt;
  logic [TICK_CNT_W-1:0]   to_cnt;
  logic                    per_clear;
  logic                    to_clear;
  logic                    timeout_hit;
  logic                    period_hit;

  // Both counters sit at zero until the handoff, so they hold 0 on the
  // first WAIT_DONE cycle. The timeout counter only matters in WAIT_DONE.
  assign per_clear   = (state == IDLE) || (state == ARM);
  assign to_clear    = (state != WAIT_DONE);
  assign timeout_hit = (state == WAIT_DONE) && gtm_clk_en && (to_cnt == TO_LAST);
  assign period_hit  = (state == GAP) && gtm_clk_en && (per_cnt == PER_LAST);

  broadsync_tick_timer #(.W(TICK_CNT_W)) u_period_timer (
    .clk   (ptp_clk),
    .rst   (ptp_reset),
    .clear (per_clear),
    .tick  (gtm_clk_en),
    .count (per_cnt)
  );

  broadsync_tick_timer #(.W(TICK_CNT_W)) u_timeout_timer (
    .clk   (ptp_clk),
    .rst   (ptp_reset),
    .clear (to_clear),
    .tick  (gtm_clk_en),
    .count (to_cnt)
  );

  always_ff @(posedge ptp_clk or posedge ptp_reset) begin
    if (ptp_reset) begin
      state         <= IDLE;
      frame_en      <= 1'b0;
      busy          <= 1'b0;
      timeout_irq   <= 1'b0;
      tx_count      <= '0;
      timeout_count <= '0;
    end else begin
      timeout_irq <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state    <= ARM;
            frame_en <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ARM: begin
          // Losing enable before the handoff abandons the request outright.
          if (!enable) begin
            state    <= IDLE;
            frame_en <= 1'b0;
            busy     <= 1'b0;
          end else if (gtm_clk_en) begin
            state    <= WAIT_DONE;
            frame_en <= 1'b0;
          end
        end
        WAIT_DONE: begin
          // A done arriving on the timeout tick still counts as success.
          if (frame_done) begin
            state    <= GAP;
            tx_count <= tx_count + TX_CNT_W'(1);
          end else if (timeout_hit) begin
            state       <= GAP;
            timeout_irq <= 1'b1;
            if (timeout_count != '1) begin
              timeout_count <= timeout_count + TO_CNT_W'(1);
            end
          end
        end
        GAP: begin
          if (period_hit) begin
            if (enable) begin
              state    <= ARM;
              frame_en <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          frame_en <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

`ifdef BROADSYNC_SCHED_LOCK_GUARD_EN
  logic [CONSEC_W-1:0] consec;
  logic [CONSEC_W-1:0] consec_next;

  always_comb begin
    consec_next = consec;
    if (state == WAIT_DONE) begin
      if (frame_done) begin
        consec_next = '0;
      end else if (timeout_hit && (consec != '1)) begin
        consec_next = consec + CONSEC_W'(1);
      end
    end
  end

  // Using the next count lets the guard bite in the same cycle the
  // threshold-reaching timeout is reported, and release right after done.
  always_ff @(posedge ptp_clk or posedge ptp_reset) begin
    if (ptp_reset) begin
      consec     <= '0;
      lock_value <= 1'b0;
    end else begin
      consec     <= consec_next;
      lock_value <= (consec_next >= CONSEC_W'(ERR_THRESH)) ? 1'b0 : lock_src;
    end
  end
`else
  always_ff @(posedge ptp_clk or posedge ptp_reset) begin
    if (ptp_reset) begin
      lock_value <= 1'b0;
    end else begin
      lock_value <= lock_src;
    end
  end
`endif

endmodule
